// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bundle: instruction-memory request/response, branch redirect, decode handshake.
// master = fetch unit, slave = memory/execute/decode environment.
interface instruction_fetch_unit_if;
    logic        mem_req_vld;
    logic        mem_req_rdy;
    logic [31:0] mem_addr;
    logic        mem_resp_vld;
    logic [31:0] mem_resp_dat;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        dec_vld;
    logic        dec_rdy;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;

    modport master (
        output mem_req_vld, mem_addr, dec_vld, dec_instr, dec_pc,
        input  mem_req_rdy, mem_resp_vld, mem_resp_dat, branch_taken, branch_target, dec_rdy
    );

    modport slave (
        input  mem_req_vld, mem_addr, dec_vld, dec_instr, dec_pc,
        output mem_req_rdy, mem_resp_vld, mem_resp_dat, branch_taken, branch_target, dec_rdy
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: PC, credit-limited memory requests, pending-PC FIFO, decode queue, redirect flush.
// Mem response to Dec valid = 1 cycle; requests stall when outstanding + queued reaches DEPTH.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    instruction_fetch_unit_if.master        io_fetch
);
    localparam int            AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW  = AW + 1;
    localparam logic [CW:0]   LIM = (CW + 1)'(DEPTH);

    logic [31:0]   r_pc;
    logic [CW-1:0] r_out_cnt;
    logic [CW-1:0] r_q_cnt;
    logic [CW-1:0] r_drop_cnt;
    logic [AW-1:0] r_pwr;
    logic [AW-1:0] r_prd;
    logic [AW-1:0] r_qwr;
    logic [AW-1:0] r_qrd;
    logic [31:0]   r_ppc  [DEPTH];
    logic [31:0]   r_qpc  [DEPTH];
    logic [31:0]   r_qins [DEPTH];

    logic          w_redirect;
    logic          w_credit;
    logic          w_req_vld;
    logic          w_accept;
    logic          w_resp;
    logic          w_keep;
    logic          w_pop;
    logic [CW-1:0] w_out_nxt;
    logic [31:0]   w_target;

    assign w_redirect = io_fetch.branch_taken;
    assign w_target   = io_fetch.branch_target & ~32'h0000_0003;
    assign w_credit   = ({1'b0, r_out_cnt} + {1'b0, r_q_cnt}) < LIM;
    // Gated by reset so nothing is offered while held, yet the first edge after release can accept.
    assign w_req_vld  = i_rst_n && w_credit && !w_redirect;
    assign w_accept   = w_req_vld && io_fetch.mem_req_rdy;
    assign w_resp     = io_fetch.mem_resp_vld;
    assign w_keep     = w_resp && !w_redirect && (r_drop_cnt == '0);
    assign w_pop      = (r_q_cnt != '0) && io_fetch.dec_rdy && !w_redirect;
    assign w_out_nxt  = r_out_cnt + CW'(w_accept) - CW'(w_resp);

    assign io_fetch.mem_req_vld = w_req_vld;
    assign io_fetch.mem_addr    = r_pc;
    assign io_fetch.dec_vld     = (r_q_cnt != '0);
    assign io_fetch.dec_instr   = r_qins[r_qrd];
    assign io_fetch.dec_pc      = r_qpc[r_qrd];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc       <= RESET_PC;
            r_out_cnt  <= '0;
            r_q_cnt    <= '0;
            r_drop_cnt <= '0;
            r_pwr      <= '0;
            r_prd      <= '0;
            r_qwr      <= '0;
            r_qrd      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_ppc[i]  <= '0;
                r_qpc[i]  <= '0;
                r_qins[i] <= '0;
            end
        end else begin
            r_out_cnt <= w_out_nxt;
            if (w_accept) begin
                r_ppc[r_pwr] <= r_pc;
                r_pwr        <= r_pwr + AW'(1);
            end
            if (w_resp) begin
                r_prd <= r_prd + AW'(1);
            end
            if (w_redirect) begin
                // Every request still in flight after this edge belongs to the abandoned path.
                r_pc       <= w_target;
                r_drop_cnt <= w_out_nxt;
                r_q_cnt    <= '0;
                r_qwr      <= '0;
                r_qrd      <= '0;
            end else begin
                if (w_accept) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (w_resp && (r_drop_cnt != '0)) begin
                    r_drop_cnt <= r_drop_cnt - CW'(1);
                end
                if (w_keep) begin
                    r_qpc[r_qwr]  <= r_ppc[r_prd];
                    r_qins[r_qwr] <= io_fetch.mem_resp_dat;
                    r_qwr         <= r_qwr + AW'(1);
                end
                if (w_pop) begin
                    r_qrd <= r_qrd + AW'(1);
                end
                r_q_cnt <= r_q_cnt + CW'(w_keep) - CW'(w_pop);
            end
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: in-order memory model (word = addr+1) and decode sink.
module tb_instruction_fetch_unit;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    instruction_fetch_unit_if bus();

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .io_fetch (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lat = 1;
    int acc_cnt = 0;
    int pop_cnt = 0;
    int first_acc = -1;
    int first_dv = -1;

    logic [31:0] mq_addr [$];
    int          mq_due  [$];
    logic [31:0] rx_pc   [$];
    logic [31:0] rx_ins  [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rx_pc_at(input int i);
        return (i < rx_pc.size()) ? rx_pc[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] rx_ins_at(input int i);
        return (i < rx_ins.size()) ? rx_ins[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic drive_resp();
        if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
            bus.mem_resp_vld = 1'b1;
            bus.mem_resp_dat = mq_addr[0] + 32'd1;
        end else begin
            bus.mem_resp_vld = 1'b0;
            bus.mem_resp_dat = 32'd0;
        end
    endtask

    // One clock: sample handshakes on the falling edge, advance the memory model after the rising edge.
    task automatic tick();
        logic        acc;
        logic        rsp;
        logic [31:0] a;
        @(negedge clk);
        acc = bus.mem_req_vld && bus.mem_req_rdy;
        a   = bus.mem_addr;
        rsp = bus.mem_resp_vld;
        if (acc) begin
            acc_cnt++;
            if (first_acc < 0) first_acc = cyc;
        end
        if (bus.dec_vld && bus.dec_rdy && !bus.branch_taken) begin
            rx_pc.push_back(bus.dec_pc);
            rx_ins.push_back(bus.dec_instr);
            pop_cnt++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rsp && mq_addr.size() > 0) begin
            mq_addr.delete(0);
            mq_due.delete(0);
        end
        if (acc) begin
            mq_addr.push_back(a);
            mq_due.push_back(cyc + lat - 1);
        end
        if (bus.dec_vld && first_dv < 0) first_dv = cyc;
        drive_resp();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        rst_n             = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'd0;
        bus.mem_req_rdy   = 1'b1;
        bus.dec_rdy       = 1'b1;
        bus.mem_resp_vld  = 1'b0;
        bus.mem_resp_dat  = 32'd0;
        mq_addr.delete();
        mq_due.delete();
        rx_pc.delete();
        rx_ins.delete();
        acc_cnt   = 0;
        pop_cnt   = 0;
        first_acc = -1;
        first_dv  = -1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic redirect(input logic [31:0] tgt);
        bus.branch_taken  = 1'b1;
        bus.branch_target = tgt;
        tick();
        bus.branch_taken  = 1'b0;
    endtask

    initial begin
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'd0;
        bus.mem_req_rdy   = 1'b1;
        bus.dec_rdy       = 1'b1;
        bus.mem_resp_vld  = 1'b0;
        bus.mem_resp_dat  = 32'd0;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst_req_vld", 32'(bus.mem_req_vld), 32'd0);
        chk("rst_addr",    bus.mem_addr,         32'h0);
        chk("rst_dec_vld", 32'(bus.dec_vld),     32'd0);
        chk("rst_instr",   bus.dec_instr,        32'd0);
        chk("rst_pc",      bus.dec_pc,           32'd0);

        // Streaming, 1-cycle memory
        lat = 1;
        do_reset();
        ticks(20);
        chk("stream_latency", 32'(first_dv - first_acc), 32'd2);
        for (int i = 0; i < 4; i++) begin
            chk("stream_pc",  rx_pc_at(i),  32'(4 * i));
            chk("stream_ins", rx_ins_at(i), 32'(4 * i + 1));
        end

        // Decode backpressure with DEPTH=2
        do_reset();
        bus.dec_rdy = 1'b0;
        ticks(8);
        chk("bp_acc",     32'(acc_cnt),          32'd2);
        chk("bp_req_vld", 32'(bus.mem_req_vld),  32'd0);
        chk("bp_dec_vld", 32'(bus.dec_vld),      32'd1);
        chk("bp_head_pc", bus.dec_pc,            32'h0);
        chk("bp_head_in", bus.dec_instr,         32'h1);
        bus.dec_rdy = 1'b1;
        tick();
        bus.dec_rdy = 1'b0;
        ticks(6);
        chk("bp1_pops",    32'(pop_cnt),         32'd1);
        chk("bp1_acc",     32'(acc_cnt),         32'd3);
        chk("bp1_head_pc", bus.dec_pc,           32'h4);
        chk("bp1_head_in", bus.dec_instr,        32'h5);
        chk("bp1_req_vld", 32'(bus.mem_req_vld), 32'd0);
        bus.dec_rdy = 1'b1;
        ticks(12);
        for (int i = 0; i < 5; i++) begin
            chk("bp_seq_pc",  rx_pc_at(i),  32'(4 * i));
            chk("bp_seq_ins", rx_ins_at(i), 32'(4 * i + 1));
        end

        // Memory not ready: request held stable
        do_reset();
        bus.mem_req_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_vld",  32'(bus.mem_req_vld), 32'd1);
            chk("hold_addr", bus.mem_addr,         32'h0);
        end
        bus.mem_req_rdy = 1'b1;
        tick();
        bus.mem_req_rdy = 1'b0;
        chk("hold_acc",  32'(acc_cnt), 32'd1);
        chk("hold_next", bus.mem_addr, 32'h4);

        // Redirect with 3-cycle memory, two in flight, response in the redirect cycle
        lat = 3;
        do_reset();
        ticks(3);
        chk("br_pre_acc", 32'(acc_cnt),      32'd2);
        chk("br_pre_rx",  32'(rx_pc.size()), 32'd0);
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h0000_0103;
        #1;
        chk("br_req_forced", 32'(bus.mem_req_vld), 32'd0);
        tick();
        bus.branch_taken = 1'b0;
        chk("br_addr",    bus.mem_addr,      32'h100);
        chk("br_dec_vld", 32'(bus.dec_vld),  32'd0);
        ticks(12);
        chk("br_pc0",  rx_pc_at(0),  32'h100);
        chk("br_ins0", rx_ins_at(0), 32'h101);
        chk("br_pc1",  rx_pc_at(1),  32'h104);

        // PC wrap at the top of the address space
        lat = 1;
        do_reset();
        redirect(32'hFFFF_FFF8);
        ticks(16);
        chk("wrap_pc0",  rx_pc_at(0),  32'hFFFF_FFF8);
        chk("wrap_pc1",  rx_pc_at(1),  32'hFFFF_FFFC);
        chk("wrap_pc2",  rx_pc_at(2),  32'h0000_0000);
        chk("wrap_ins2", rx_ins_at(2), 32'h0000_0001);

        // Asynchronous reset with a full queue
        do_reset();
        redirect(32'h0000_0040);
        bus.dec_rdy = 1'b0;
        ticks(8);
        chk("ar_pre_vld", 32'(bus.dec_vld), 32'd1);
        chk("ar_pre_pc",  bus.dec_pc,       32'h40);
        chk("ar_pre_in",  bus.dec_instr,    32'h41);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_dec_vld", 32'(bus.dec_vld),     32'd0);
        chk("ar_dec_pc",  bus.dec_pc,           32'd0);
        chk("ar_dec_in",  bus.dec_instr,        32'd0);
        chk("ar_req_vld", 32'(bus.mem_req_vld), 32'd0);
        chk("ar_addr",    bus.mem_addr,         32'h0);
        do_reset();
        ticks(10);
        chk("ar_restart_pc",  rx_pc_at(0),  32'h0);
        chk("ar_restart_ins", rx_ins_at(0), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Initiator side of the instruction-memory interface. Owns the program counter, issues word fetch requests to instruction memory, and pairs in-order responses with their PCs. Buffers fetched instructions in a small queue and presents them to the decode stage over a valid/ready handshake. Handles branch redirects by flushing the queue and discarding stale in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset (bits [1:0] must be 0)
DEPTH, 2, max outstanding requests plus buffered instructions (power of 2, 2..8)

Ports:
Clock  input  1  system clock, all state updates on rising edge
Reset_n  input  1  asynchronous active-low reset
Mem_Req_Valid  output  1  fetch request valid
Mem_Req_Ready  input  1  memory accepts request this cycle
Mem_Addr  output  32  byte address of requested word
Mem_Resp_Valid  input  1  response data valid (in order, >=1 cycle after acceptance)
Mem_Resp_Data  input  32  fetched instruction word
Branch_Taken  input  1  redirect strobe from execute, single cycle
Branch_Target  input  32  redirect address
Dec_Valid  output  1  instruction available to decode
Dec_Ready  input  1  decode consumes instruction
Dec_Instruction  output  32  instruction word at queue head
Dec_PC  output  32  PC of Dec_Instruction

Behaviour:
- Reset (Reset_n=0, async): fetch PC=RESET_PC, queue empty, outstanding=0, drop count=0; Mem_Req_Valid=0, Mem_Addr=RESET_PC, Dec_Valid=0, Dec_Instruction=0, Dec_PC=0. Reset asserted mid-operation aborts everything; in-flight responses arriving after release are not expected (memory is reset by the same Reset_n).
- Mem_Req_Valid=1 when outstanding + queue_count < DEPTH and no redirect is in progress this cycle; first request possible on the first edge after Reset_n rises. Mem_Addr = fetch PC.
- Acceptance = Mem_Req_Valid & Mem_Req_Ready: fetch PC += 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0); the accepted address is pushed into an internal pending-PC FIFO (DEPTH entries); outstanding += 1.
- Mem_Req_Valid may drop without acceptance only on a redirect; otherwise Mem_Addr stays stable while Valid=1 and Ready=0.
- Response (Mem_Resp_Valid=1): pop pending-PC FIFO, outstanding -= 1. If drop count > 0: decrement it and discard the data. Otherwise push {PC, data} into the instruction queue. The queue never overflows due to the credit rule.
- Decode side: Dec_Valid = queue not empty; Dec_Instruction/Dec_PC = head entry, registered, stable while Dec_Valid=1 and Dec_Ready=0. Pop on Dec_Valid & Dec_Ready. Push and pop in the same cycle are both honored. An empty queue with a response arriving presents it on Dec_Valid the next cycle (Mem_Resp to Dec_Valid latency = 1).
- Redirect (Branch_Taken=1), same-cycle effects at the edge:
  - Queue flushed; Dec_Valid=0 next cycle, even if Dec_Ready was high, and the head is not consumed.
  - Drop count = outstanding after this cycle's acceptance/response updates. A request accepted in the redirect cycle is included. A response arriving in the redirect cycle is discarded.
  - Fetch PC = {Branch_Target[31:2], 2'b00}; low two bits are ignored.
  - Mem_Req_Valid is forced 0 in the redirect cycle. A new request at the target is issued from the next cycle, subject to credits.
- Back-to-back redirects: the last one wins. Drop count is recomputed each time.
- Simultaneous accept + response in one cycle: outstanding unchanged.
- Pending-PC FIFO and instruction queue pointers wrap modulo DEPTH.

Test Plan:
- Reset release, RESET_PC=0, Mem_Req_Ready=1, 1-cycle memory returning word = addr+1: Dec stream PC 0,4,8,... with Instruction 1,5,9,...; first Dec_Valid 2 cycles after first acceptance.
- Dec_Ready=0 with DEPTH=2: exactly 2 requests accepted, then Mem_Req_Valid=0. Dec_Ready=1 for one cycle: one pop, one new request. No data lost or duplicated.
- Mem_Req_Ready held 0 for 5 cycles: Mem_Req_Valid=1 and Mem_Addr constant throughout. Then accepted once and PC advances by 4.
- 3-cycle memory latency with 2 outstanding, Branch_Taken to 0x100 in the same cycle as a response: both old responses dropped. The next Dec_PC=0x100. Branch_Target=0x103 is fetched as 0x100.
- Fetch PC=0xFFFF_FFF8: Dec_PC sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Reset_n pulsed low mid-stream with a full queue: outputs clear immediately (asynchronously). After release, fetching restarts at RESET_PC.
